// File: rtl/hydra_sched_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | hydra_sched_pkg: shared sizes, id types and port states               |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package hydra_sched_pkg;

  localparam int NUM_PORTS = 16;
  localparam int NUM_SRAMS = 32;

  typedef logic [3:0] port_id_t;
  typedef logic [4:0] sram_id_t;

  typedef enum logic {
    FREE = 1'b0,
    HOLD = 1'b1
  } port_state_t;

endpackage
`default_nettype wire

// File: rtl/claim_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | claim_rr_arbiter: one-hot pick of the first request at/after ptr_i    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module claim_rr_arbiter #(
  parameter int N  = hydra_sched_pkg::NUM_PORTS,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);
  import hydra_sched_pkg::*;

  logic          found;
  logic [PW-1:0] idx;

  // N is a power of two, so the cyclic index wraps for free in PW bits.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr_i + PW'(k);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_claim_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sram_claim_scheduler: rotating SRAM offers, claim arbitration and the |
// | SRAM ownership table. Option: HYDRA_RELEASE_BYPASS_EN. Rev 1.0        |
// +-----------------------------------------------------------------------+
module sram_claim_scheduler #(
  parameter int NUM_PORTS = hydra_sched_pkg::NUM_PORTS,
  parameter int NUM_SRAMS = hydra_sched_pkg::NUM_SRAMS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [NUM_PORTS*5-1:0] scan_sram_o,
  output logic [NUM_PORTS-1:0]   scan_accessible_o,
  input  logic [NUM_PORTS-1:0]   claim_valid_i,
  input  logic [NUM_PORTS*5-1:0] claim_sram_i,
  output logic [NUM_PORTS-1:0]   claim_grant_o,
  output logic [NUM_PORTS-1:0]   claim_deny_o,
  input  logic [NUM_PORTS-1:0]   release_i,
  output logic [NUM_PORTS-1:0]   port_owns_o,
  output logic [NUM_SRAMS-1:0]   sram_busy_o
);
  import hydra_sched_pkg::*;

  sram_id_t             offset_q, offset_d;
  sram_id_t             scan_q      [NUM_PORTS];
  port_state_t          state_q     [NUM_PORTS];
  sram_id_t             port_sram_q [NUM_PORTS];
  sram_id_t             claim_sram_w[NUM_PORTS];
  port_id_t             rr_ptr_q, rr_ptr_d;
  logic [NUM_SRAMS-1:0] busy_q, busy_d, busy_eval, rel_mask, grant_mask;
  logic [NUM_PORTS-1:0] grant_q, deny_q, rel_eff, eligible, grant_w;
  logic [NUM_PORTS-1:0] req [NUM_SRAMS];
  logic [NUM_PORTS-1:0] win [NUM_SRAMS];

  assign offset_d      = offset_q + sram_id_t'(1);
  assign claim_grant_o = grant_q;
  assign claim_deny_o  = deny_q;
  assign sram_busy_o   = busy_q;

  always_comb begin
    rel_mask = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rel_eff[p]) rel_mask[port_sram_q[p]] = 1'b1;
    end
  end

`ifdef HYDRA_RELEASE_BYPASS_EN
  assign busy_eval = busy_q & ~rel_mask;
`else
  assign busy_eval = busy_q;
`endif

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign claim_sram_w[p]         = claim_sram_i[5*p +: 5];
    assign scan_sram_o[5*p +: 5]   = scan_q[p];
    assign scan_accessible_o[p]    = ~busy_eval[scan_q[p]];
    assign port_owns_o[p]          = (state_q[p] == HOLD);
    assign rel_eff[p]              = release_i[p] & (state_q[p] == HOLD);
    // A port releasing this cycle competes as if already FREE.
    assign eligible[p] = claim_valid_i[p]
                       & ((state_q[p] == FREE) | rel_eff[p])
                       & ~busy_eval[claim_sram_w[p]];
  end

  always_comb begin
    for (int s = 0; s < NUM_SRAMS; s++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        req[s][p] = eligible[p] & (claim_sram_w[p] == sram_id_t'(s));
      end
    end
  end

  for (genvar s = 0; s < NUM_SRAMS; s++) begin : g_arb
    claim_rr_arbiter #(
      .N (NUM_PORTS)
    ) u_arb (
      .req_i (req[s]),
      .ptr_i (rr_ptr_q),
      .gnt_o (win[s])
    );
  end

  always_comb begin
    grant_w    = '0;
    grant_mask = '0;
    for (int s = 0; s < NUM_SRAMS; s++) begin
      grant_w       = grant_w | win[s];
      grant_mask[s] = |win[s];
    end
    rr_ptr_d = rr_ptr_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_w[p]) rr_ptr_d = port_id_t'(p + 1);
    end
    // Set after clear so a bypassed release+claim transfers ownership in one edge.
    busy_d = (busy_q & ~rel_mask) | grant_mask;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      offset_q <= '0;
      rr_ptr_q <= '0;
      busy_q   <= '0;
      grant_q  <= '0;
      deny_q   <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        state_q[p]     <= FREE;
        port_sram_q[p] <= '0;
        scan_q[p]      <= sram_id_t'(2 * p);
      end
    end else begin
      offset_q <= offset_d;
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
      grant_q  <= grant_w;
      deny_q   <= claim_valid_i & ~grant_w;
      for (int p = 0; p < NUM_PORTS; p++) begin
        scan_q[p] <= sram_id_t'(2 * p) + offset_d;
        if (grant_w[p]) begin
          state_q[p]     <= HOLD;
          port_sram_q[p] <= claim_sram_w[p];
        end else if (rel_eff[p]) begin
          state_q[p] <= FREE;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/sram_claim_scheduler.md
Name: sram_claim_scheduler

Overview:
- Shares the 32 packet SRAMs among the 16 write ports.
- Each port's SRAM matcher is offered a distinct SRAM every cycle through a rotating scan schedule, together with that SRAM's availability.
- The scheduler arbitrates the resulting claims and keeps the SRAM ownership table.
- Sits between the per-port write matchers and the SRAM bank; it is the sole authority on which port may write which SRAM.

Parameters:
- NUM_PORTS, 16, number of write ports (power of two).
- NUM_SRAMS, 32, number of SRAMs (must equal 2*NUM_PORTS).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- scan_sram  out  NUM_PORTS*5  SRAM index offered to port p, slice [5p+4:5p]
- scan_accessible  out  NUM_PORTS  offered SRAM currently unowned
- claim_valid  in  NUM_PORTS  single-cycle claim request from port p
- claim_sram  in  NUM_PORTS*5  SRAM index claimed by port p
- claim_grant  out  NUM_PORTS  one-cycle pulse, claim accepted
- claim_deny  out  NUM_PORTS  one-cycle pulse, claim refused
- release  in  NUM_PORTS  port p frees the SRAM it owns
- port_owns  out  NUM_PORTS  port p currently holds an SRAM
- sram_busy  out  NUM_SRAMS  SRAM s is owned

Behaviour:
- Reset: scan offset=0, rr_ptr=0, all ownership cleared. claim_grant, claim_deny, port_owns, sram_busy=0. scan_sram[p]=2p.
- Scan schedule:
  - 5-bit offset increments every cycle, wrapping 31->0.
  - scan_sram[p] is registered, = (2p + offset) mod 32, so all 16 offers are distinct each cycle. Every port sees every SRAM once per 32 cycles.
- scan_accessible[p] is combinational: ~sram_busy[scan_sram[p]].
- Per-port FSM:
  - FREE -> HOLD on grant.
  - HOLD -> FREE on release.
  - port_sram[p] (5b) is latched on grant.
- Claim evaluation happens in the cycle claim_valid is high. Response is registered: exactly one of grant/deny pulses in the next cycle, for exactly 1 cycle.
- Deny if any of the following holds:
  - port already in HOLD;
  - SRAM busy at evaluation time;
  - another port wins arbitration for the same SRAM.
- Arbitration:
  - Among same-cycle eligible claimants of one SRAM, the winner is the first port index at or after rr_ptr, scanning cyclically mod 16.
  - rr_ptr is a single global 4-bit pointer. It updates to (highest-numbered granted port)+1 after any cycle with at least one grant; otherwise it is unchanged.
  - Different SRAMs may be granted in the same cycle.
- Grant updates ownership in the same edge as the claim_grant pulse: sram_busy[s]=1, owner=p, port_owns[p]=1.
- Release:
  - Clears ownership on the next edge.
  - Release while FREE is ignored.
  - release and claim_valid from the same port in one cycle: release is applied and the claim is evaluated as FREE. The SRAM is still busy that cycle unless bypass is enabled.
- Release of SRAM s in the same cycle another port claims s: claim denied (no bypass, see option).
- Reset mid-operation clears all ownership at once. Pending responses are dropped; no grant/deny pulse follows reset.

Optional Feature:
- Macro: HYDRA_RELEASE_BYPASS_EN.
- Defined: an SRAM being released this cycle is treated as free for claim evaluation and scan_accessible in the same cycle. A same-cycle release+claim of s yields a grant, and ownership transfers in one edge.
- Undefined: a released SRAM becomes claimable one cycle after release.

Decomposition:
- Package hydra_sched_pkg:
  - NUM_PORTS, NUM_SRAMS;
  - typedefs port_id_t (4b) and sram_id_t (5b);
  - enum port_state_t {FREE, HOLD}.
- One sub-module, claim_rr_arbiter: 16-bit request vector + rr_ptr -> one-hot winner. Instantiated per SRAM, or time-shared via a generate loop over SRAMs.

Test Plan:
- Reset, then idle 40 cycles -> scan_sram[0] reads 0,1,...,31,0; scan_sram[3] starts at 6; all scan_accessible=1; no grant/deny pulses.
- Port 5 claims SRAM 11 -> claim_grant[5] pulses next cycle; sram_busy[11]=1; port_owns[5]=1. When port 7 is later offered SRAM 11, scan_accessible[7]=0.
- Ports 2 and 9 claim SRAM 4 in the same cycle with rr_ptr=3 -> grant[9], deny[2]; rr_ptr becomes 10. Repeat with rr_ptr=10 -> port 2 wins.
- Port 5, holding SRAM 11, claims SRAM 12 -> deny[5]; ownership unchanged. Port 5 then asserts release -> sram_busy[11]=0 next cycle.
- Port 1 releases SRAM 11 while port 6 claims SRAM 11 in the same cycle -> deny[6] without HYDRA_RELEASE_BYPASS_EN; grant[6] and sram_busy[11] stays 1 with it.
- Three grants held, rst_n low for 1 cycle -> sram_busy=0, port_owns=0, offset=0, no response pulses after reset.
